// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer, four-state settle FSM and
// registered level / press / release / long-press outputs.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (long-press detector);
// when it is undefined the long-press counter is absent and long_press_o is 0.
//
// state          | meaning
// RELEASED       | button accepted as up, waiting for a high sample
// SETTLE_PRESS   | high seen, counting stable high cycles before accepting press
// PRESSED        | button accepted as down, waiting for a low sample
// SETTLE_RELEASE | low seen, counting stable low cycles before accepting release
`timescale 1ns/1ps

module button_debounce #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int          CNT_W    = 26;
    localparam int          CNT_LIM  = (1 << CNT_W) - 1;
    localparam logic [25:0] DEB_LAST = 26'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] CNT_MAX  = '1;

    // Reject parameter values the 26-bit counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > CNT_LIM) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..2^26-1");
    end
    if (LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES > CNT_LIM) begin : g_bad_long_press
        $error("LONG_PRESS_CYCLES out of range 1..2^26-1");
    end

    typedef enum logic [1:0] {
        RELEASED       = 2'd0,
        SETTLE_PRESS   = 2'd1,
        PRESSED        = 2'd2,
        SETTLE_RELEASE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2;
    logic [25:0] cnt, cnt_nxt;
    logic        press_nxt, release_nxt, level_nxt;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
        end
    end

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RELEASED;
            cnt       <= '0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_o   <= level_nxt;
            press_o   <= press_nxt;
            release_o <= release_nxt;
        end
    end

    // Next-state, counter and pulse decode from the synchronized sample.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (sync2) begin
                    state_nxt = SETTLE_PRESS;
                    cnt_nxt   = '0;
                end
            end
            SETTLE_PRESS: begin
                if (!sync2) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 26'd1;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_nxt = SETTLE_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            SETTLE_RELEASE: begin
                if (sync2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = RELEASED;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 26'd1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == PRESSED) || (state_nxt == SETTLE_RELEASE);
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [25:0] LP_LAST   = 26'(LONG_PRESS_CYCLES - 1);
    localparam logic [25:0] LP_TARGET = 26'(LONG_PRESS_CYCLES);

    logic [25:0] lcnt;
    logic        held;

    assign held = (state == PRESSED) || (state == SETTLE_RELEASE);

    // Hold-time counter: restarts on an accepted press, parks at the threshold
    // so the pulse fires once per press. A release on the same edge wins, and
    // the check only runs while already held so it never lands on the press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt         <= '0;
            long_press_o <= 1'b0;
        end else begin
            long_press_o <= 1'b0;
            if (press_nxt) begin
                lcnt <= '0;
            end else if (held) begin
                if (lcnt != LP_TARGET) begin
                    lcnt <= lcnt + 26'd1;
                end
                if (lcnt == LP_LAST && !release_nxt) begin
                    long_press_o <= 1'b1;
                end
            end
        end
    end
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
// A run-length reference model predicts outputs per clock; predictions are
// queued when the input is driven and compared after the sampling edge.
`timescale 1ns/1ps

module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic level_o, press_o, release_o, long_press_o;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn),
        .level_o     (level_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .long_press_o(long_press_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    logic m_sync1, m_sync2, m_level;
    int   m_run, m_hold;

    int cyc = 0;
    int press_cnt = 0, release_cnt = 0, long_cnt = 0;
    int last_press_cyc = -1, last_long_cyc = -1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sync1 = 1'b0;
        m_sync2 = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        m_hold  = L;
    endtask

    // Predict the outputs after the coming rising edge.
    task automatic model_edge();
        logic s, p, r, lp, old_level;
        int hold_prev;
        p = 1'b0; r = 1'b0; lp = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            s = m_sync2;
            old_level = m_level;
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_level = ~m_level;
                m_run   = 0;
                if (m_level) p = 1'b1;
                else r = 1'b1;
            end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            if (p) begin
                m_hold = 0;
            end else if (old_level) begin
                hold_prev = m_hold;
                if (m_hold < L) m_hold++;
                lp = (hold_prev == L - 1) && !r;
            end
`else
            hold_prev = m_hold;
            m_hold = hold_prev;
`endif
            m_sync2 = m_sync1;
            m_sync1 = btn;
        end
        exp_q.push_back({m_level, p, r, lp});
    endtask

    task automatic step(input logic b, input logic r);
        logic [3:0] e;
        @(negedge clk);
        rst_n = r;
        btn = b;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_val("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("sb", {level_o, press_o, release_o, long_press_o}, e);
        end
        if (press_o) begin press_cnt++; last_press_cyc = cyc; end
        if (release_o) release_cnt++;
        if (long_press_o) begin long_cnt++; last_long_cyc = cyc; end
    endtask

    task automatic hold_until(input logic b, output int idx);
        idx = -1;
        for (int i = 0; i < 20; i++) begin
            step(b, 1'b1);
            if (idx < 0 && (b ? press_o : release_o)) idx = i;
        end
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val(tag, {level_o, press_o, release_o, long_press_o}, 4'h0);
        model_reset();
    endtask

    initial begin
        int idx;
        int len;
        logic v;
        model_reset();
        repeat (3) step(1'b0, 1'b0);
        check_val("reset_outputs", {level_o, press_o, release_o, long_press_o}, 4'h0);

        // Clean press: accepted six edges after the first sampling edge.
        hold_until(1'b1, idx);
        check_val("press_latency", idx, 6);
        check_val("press_level", level_o, 1);
        check_val("press_count", press_cnt, 1);

        // Keep holding well past the long-press threshold.
        repeat (20) step(1'b1, 1'b1);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        check_val("long_count", long_cnt, 1);
        check_val("long_delay", last_long_cyc - last_press_cyc, L);
`else
        check_val("long_absent", long_cnt, 0);
`endif

        // Short low glitch while pressed.
        repeat (3) step(1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b1);
        check_val("rel_glitch_count", release_cnt, 0);
        check_val("rel_glitch_level", level_o, 1);

        // Clean release.
        hold_until(1'b0, idx);
        check_val("release_latency", idx, 6);
        check_val("release_level", level_o, 0);
        check_val("release_count", release_cnt, 1);

        // High glitches of 3 and D cycles are rejected; D+1 is accepted.
        repeat (3) step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        check_val("glitch3_press", press_cnt, 1);
        repeat (D) step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        check_val("glitchD_press", press_cnt, 1);
        check_val("glitchD_level", level_o, 0);
        repeat (D + 1) step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        check_val("pulseD1_press", press_cnt, 2);
        check_val("pulseD1_release", release_cnt, 2);

        // Reset mid-settle, then re-qualify with full latency.
        repeat (5) step(1'b1, 1'b1);
        async_reset_check("rst_mid_settle");
        repeat (2) step(1'b1, 1'b0);
        check_val("rst_settle_press", press_cnt, 2);
        hold_until(1'b1, idx);
        check_val("requalify_latency", idx, 6);
        check_val("requalify_count", press_cnt, 3);

        // Reset while pressed must not emit a release.
        async_reset_check("rst_mid_press");
        repeat (2) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        check_val("rst_press_release", release_cnt, 2);
        check_val("rst_press_level", level_o, 0);

        // Random bouncing runs.
        v = 1'b0;
        for (int k = 0; k < 60; k++) begin
            v = ~v;
            len = $urandom_range(1, 9);
            repeat (len) step(v, 1'b1);
        end
        repeat (12) step(1'b0, 1'b1);
        check_val("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
